action_limiter: RTL and testbench

ACTION_LIMITER -- requirements
Module: action_limiter

---
 rtl/action_limiter_pkg.sv | 12 +
 rtl/action_saturate.sv | 28 ++
 rtl/action_limiter.sv | 129 ++++++++++++
 tb/tb_action_limiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/action_limiter_pkg.sv
// Shared types and defaults for the action limiter (PI action -> DAC word).
package action_limiter_pkg;
  localparam int IN_WIDTH_DEF  = 32;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int RAIL_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_TRACK,
    ST_RAILED,
    ST_RELOCK
  } state_e;
endpackage

// File: rtl/action_saturate.sv
// Combinational shift-and-clamp of one action word. IN_W must exceed OUT_W.
module action_saturate #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_data,
  input  logic        [4:0]       i_shift,
  input  logic signed [OUT_W-1:0] i_min,
  input  logic signed [OUT_W-1:0] i_max,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_clamped
);
  logic signed [IN_W-1:0] w_v, w_min, w_max, w_hi, w_lo;
  logic                   w_hi_hit, w_lo_hit;

  // Max is applied first, then min, so min wins on inverted limits.
  always_comb begin
    w_v      = i_data >>> i_shift;
    w_min    = {{(IN_W-OUT_W){i_min[OUT_W-1]}}, i_min};
    w_max    = {{(IN_W-OUT_W){i_max[OUT_W-1]}}, i_max};
    w_hi_hit = w_v > w_max;
    w_hi     = w_hi_hit ? w_max : w_v;
    w_lo_hit = w_hi < w_min;
    w_lo     = w_lo_hit ? w_min : w_hi;
    o_data    = w_lo[OUT_W-1:0];
    o_clamped = w_hi_hit || w_lo_hit;
  end
endmodule

// File: rtl/action_limiter.sv
// Clamps PI actions onto a DAC stream, counts consecutive rail hits and
// drives an integrator-reset (relock) pulse when the loop stays railed.
module action_limiter
  import action_limiter_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic signed [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic        [4:0]           cfg_shift,
  input  logic signed [OUT_WIDTH-1:0] cfg_min,
  input  logic signed [OUT_WIDTH-1:0] cfg_max,
  input  logic [RAIL_CNT_W-1:0]       cfg_rail_count,
  input  logic [RAIL_CNT_W-1:0]       cfg_relock_len,
  input  logic                        relock_en,
  output logic                        pi_rst,
  output logic                        railed,
  output logic                        locked
);
  state_e                    r_state, w_state_nxt;
  logic [RAIL_CNT_W-1:0]     r_rail_cnt, w_rail_cnt_nxt, w_cnt_inc;
  logic [RAIL_CNT_W-1:0]     r_rl_cnt, r_rl_len;
  logic                      r_relock_en_d;
  logic signed [OUT_WIDTH-1:0] w_sat;
  logic                      w_clamped, w_accept, w_enter_relock, w_take;
  logic signed [OUT_WIDTH:0] w_mid_sum;

  action_saturate #(.IN_W(IN_WIDTH), .OUT_W(OUT_WIDTH)) u_sat (
    .i_data   (s_axis_tdata),
    .i_shift  (cfg_shift),
    .i_min    (cfg_min),
    .i_max    (cfg_max),
    .o_data   (w_sat),
    .o_clamped(w_clamped)
  );

  // During relock inputs are swallowed, so the port always reads ready.
  assign s_axis_tready = (r_state == ST_RELOCK) || !m_axis_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  // One extra bit keeps the limit sum from overflowing before halving.
  assign w_mid_sum     = {cfg_min[OUT_WIDTH-1], cfg_min} + {cfg_max[OUT_WIDTH-1], cfg_max};

  // Next state, rail counter, and whether this edge loads a sample or the midpoint.
  always_comb begin
    w_state_nxt    = r_state;
    w_rail_cnt_nxt = r_rail_cnt;
    w_enter_relock = 1'b0;
    w_cnt_inc      = (r_rail_cnt == '1) ? r_rail_cnt : r_rail_cnt + 1'b1;
    case (r_state)
      ST_TRACK: begin
        if (w_accept) begin
          if (w_clamped) begin
            w_rail_cnt_nxt = w_cnt_inc;
            if (cfg_rail_count != '0 && w_cnt_inc >= cfg_rail_count) begin
              w_state_nxt    = relock_en ? ST_RELOCK : ST_RAILED;
              w_enter_relock = relock_en;
            end
          end else begin
            w_rail_cnt_nxt = '0;
          end
        end
      end
      ST_RAILED: begin
        if (w_accept && !w_clamped) begin
          w_state_nxt    = ST_TRACK;
          w_rail_cnt_nxt = '0;
        end else if (relock_en && !r_relock_en_d) begin
          w_state_nxt    = ST_RELOCK;
          w_enter_relock = 1'b1;
        end
      end
      ST_RELOCK: begin
        if (r_rl_cnt == r_rl_len) begin
          w_state_nxt    = ST_TRACK;
          w_rail_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_TRACK;
    endcase
    w_take = w_accept && (r_state != ST_RELOCK) && !w_enter_relock;
  end

  // FSM state, counters, output register and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_TRACK;
      r_rail_cnt    <= '0;
      r_rl_cnt      <= '0;
      r_rl_len      <= '0;
      r_relock_en_d <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      pi_rst        <= 1'b0;
      railed        <= 1'b0;
      locked        <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_rail_cnt    <= w_rail_cnt_nxt;
      r_relock_en_d <= relock_en;
      railed        <= (w_state_nxt == ST_RAILED);
      locked        <= (w_state_nxt == ST_TRACK) && (w_rail_cnt_nxt == '0);
      if (w_enter_relock) begin
        r_rl_cnt      <= '0;
        r_rl_len      <= cfg_relock_len;
        pi_rst        <= 1'b1;
        m_axis_tdata  <= w_mid_sum[OUT_WIDTH:1];
        m_axis_tvalid <= 1'b1;
      end else begin
        if (r_state == ST_RELOCK) begin
          if (w_state_nxt != ST_RELOCK) pi_rst   <= 1'b0;
          else                          r_rl_cnt <= r_rl_cnt + 1'b1;
        end
        if (w_take) begin
          m_axis_tdata  <= w_sat;
          m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_action_limiter.sv
// Directed bench for action_limiter: clamp table plus relock/railed sequences.
module tb_action_limiter;
  localparam int IW = 32;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [IW-1:0] s_tdata;
  logic                 s_tvalid, s_tready;
  logic signed [OW-1:0] m_tdata;
  logic                 m_tvalid, m_tready;
  logic [4:0]           cfg_shift;
  logic signed [OW-1:0] cfg_min, cfg_max;
  logic [15:0]          cfg_rail_count, cfg_relock_len;
  logic                 relock_en, pi_rst, railed, locked;

  int n_checks = 0;
  int n_errors = 0;

  action_limiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .cfg_shift(cfg_shift), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_rail_count(cfg_rail_count), .cfg_relock_len(cfg_relock_len),
    .relock_en(relock_en), .pi_rst(pi_rst), .railed(railed), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    step();
  endtask

  typedef struct {
    logic [31:0] din;
    logic [4:0]  sh;
    int          mn;
    int          mx;
    int          q;
    logic        lk;
  } vec_t;

  vec_t vt[11];
  int   pulse;

  initial begin
    vt[0]  = '{32'h0064_0000, 5'd16, -1000,  1000,   100, 1'b1};
    vt[1]  = '{32'h7FFF_0000, 5'd16, -1000,  1000,  1000, 1'b0};
    vt[2]  = '{32'h8000_0000, 5'd16, -1000,  1000, -1000, 1'b0};
    vt[3]  = '{32'd1000,      5'd0,  -1000,  1000,  1000, 1'b1};
    vt[4]  = '{32'd1001,      5'd0,  -1000,  1000,  1000, 1'b0};
    vt[5]  = '{32'hFFFF_FC18, 5'd0,  -1000,  1000, -1000, 1'b1};
    vt[6]  = '{32'hFFFF_FFFF, 5'd4,  -1000,  1000,    -1, 1'b1};
    vt[7]  = '{32'h8000_0000, 5'd31, -1000,  1000,    -1, 1'b1};
    vt[8]  = '{32'd0,         5'd0,     50,   -50,    50, 1'b0};
    vt[9]  = '{32'h7FFF_FFFF, 5'd8, -32768, 32767, 32767, 1'b0};
    vt[10] = '{32'd4000,      5'd3,  -1000,  1000,   500, 1'b1};

    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    cfg_shift = 5'd0; cfg_min = -16'sd1000; cfg_max = 16'sd1000;
    cfg_rail_count = 16'd0; cfg_relock_len = 16'd7; relock_en = 1'b0;
    repeat (2) step();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata",  m_tdata, 0);
    chk("rst_pi_rst", pi_rst, 0);
    chk("rst_railed", railed, 0);
    chk("rst_locked", locked, 1);
    @(negedge clk) rst = 1'b0;
    step();
    chk("post_rst_tready", s_tready, 1);

    // Clamp table: rail detection disabled, locked mirrors "not clamped".
    for (int i = 0; i < 11; i++) begin
      cfg_shift = vt[i].sh;
      cfg_min   = 16'(vt[i].mn);
      cfg_max   = 16'(vt[i].mx);
      send(vt[i].din);
      chk($sformatf("vec%0d_data", i), m_tdata, vt[i].q);
      chk($sformatf("vec%0d_valid", i), m_tvalid, 1);
      chk($sformatf("vec%0d_locked", i), locked, {31'd0, vt[i].lk});
    end

    // Backpressure: output held, input stalled, nothing lost.
    cfg_shift = 5'd0; cfg_min = -16'sd1000; cfg_max = 16'sd1000;
    send(32'd11);
    m_tready = 1'b0;
    s_tdata  = 32'd22;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_tready", s_tready, 0);
      chk("bp_hold", m_tdata, 11);
      chk("bp_valid", m_tvalid, 1);
    end
    m_tready = 1'b1;
    step();
    chk("bp_release", m_tdata, 22);
    s_tvalid = 1'b0;
    step();
    chk("bp_drain", m_tvalid, 0);

    // Four railed samples with relock enabled -> midpoint and 8-cycle pi_rst.
    cfg_rail_count = 16'd4; relock_en = 1'b1; cfg_relock_len = 16'd7;
    for (int i = 0; i < 3; i++) send(32'd5000);
    chk("rl_pre_data", m_tdata, 1000);
    chk("rl_pre_locked", locked, 0);
    chk("rl_pre_pi", pi_rst, 0);
    s_tdata = 32'd5000;
    step();
    chk("rl_mid", m_tdata, 0);
    chk("rl_mid_valid", m_tvalid, 1);
    chk("rl_pi_on", pi_rst, 1);
    s_tdata = 32'd7;
    pulse = 1;
    for (int i = 0; i < 20 && pi_rst; i++) begin
      chk("rl_tready", s_tready, 1);
      step();
      if (pi_rst) pulse++;
    end
    chk("rl_pulse_len", pulse, 8);
    chk("rl_exit_locked", locked, 1);
    chk("rl_discard", m_tdata, 0);
    s_tvalid = 1'b0;
    step();

    // Relock disabled: railed flag, no pulse, recovery on an in-range sample.
    relock_en = 1'b0;
    for (int i = 0; i < 4; i++) send(32'd5000);
    s_tvalid = 1'b0;
    chk("rd_railed", railed, 1);
    repeat (3) step();
    chk("rd_hold", railed, 1);
    chk("rd_no_pi", pi_rst, 0);
    send(32'd5);
    chk("rd_exit_railed", railed, 0);
    chk("rd_exit_locked", locked, 1);
    chk("rd_exit_data", m_tdata, 5);

    // Railed again, then relock_en rises; relock length latched on entry.
    for (int i = 0; i < 4; i++) send(32'd5000);
    s_tvalid = 1'b0;
    chk("rr_railed", railed, 1);
    cfg_max   = 16'sd2000;
    relock_en = 1'b1;
    step();
    chk("rr_pi_on", pi_rst, 1);
    chk("rr_mid", m_tdata, 500);
    cfg_relock_len = 16'd2;
    pulse = 1;
    for (int i = 0; i < 20 && pi_rst; i++) begin
      step();
      if (pi_rst) pulse++;
    end
    chk("rr_pulse_len", pulse, 8);
    chk("rr_locked", locked, 1);

    // rst three cycles into relock; midpoint needs the extra sum bit.
    cfg_min = 16'sd30000; cfg_max = 16'sd32000; cfg_relock_len = 16'd7;
    for (int i = 0; i < 4; i++) send(32'd40000);
    s_tvalid = 1'b0;
    chk("ar_mid", m_tdata, 31000);
    chk("ar_pi_on", pi_rst, 1);
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    chk("ar_pi_off", pi_rst, 0);
    chk("ar_tvalid", m_tvalid, 0);
    chk("ar_tdata", m_tdata, 0);
    chk("ar_railed", railed, 0);
    chk("ar_locked", locked, 1);
    @(negedge clk) rst = 1'b0;
    step();
    chk("ar_tready", s_tready, 1);
    chk("ar_pi_stay", pi_rst, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
